lsu: RTL

Parametrised load/store unit for the rv32i core, sitting between the execute stage and a private on-chip data memory. It accepts one request at a time over a valid/ready handshake and supports byte, halfword and word accesses with byte-enable stores. Loads are sign- or zero-extended, and misaligned requests are flagged without touching memory. It is the next generation of the word-only single-port data memory and is a drop-in replacement at the same pipeline position.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/dmem_bank.sv | 28 ++
 rtl/lsu.sv | 108 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size and FSM encodings,
// the captured-request record, and the alignment/byte-enable decoders.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } lsu_state_e;

    typedef struct packed {
        logic      write;
        lsu_size_e size;
        logic      is_unsigned;
        logic [1:0] byte_off;
    } lsu_req_t;

    function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return off[0];
            WORD:    return |off;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(lsu_size_e size, logic [1:0] off);
        case (size)
            BYTE:    return 4'b0001 << off;
            HALF:    return 4'b0011 << off;
            WORD:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled single-port data RAM: one 8-bit array per lane, registered read, no reset.
module dmem_bank #(
    parameter  int DEPTH_WORDS = 4096,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             rd_en,
    input  logic [3:0]       wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] q;

        always_ff @(posedge clk_i) begin
            if (wr_en[l])
                mem[idx] <= wdata[8*l +: 8];
            if (rd_en)
                q <= mem[idx];
        end

        assign rdata[8*l +: 8] = q;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, byte/half/word with byte-enable stores,
// sign/zero-extended loads, misaligned requests answered with an error and no memory access.
module lsu
    import lsu_pkg::*;
#(
    parameter  int DEPTH_WORDS = 4096,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rdata_o
);

    lsu_state_e state_q, state_d;
    lsu_req_t   req_q;
    lsu_size_e  size;
    logic       accept, req_err, do_write, do_read;
    logic [3:0] wr_en;
    logic [31:0] wr_data, rd_word, shifted, load_fmt;
    logic       unused_addr;

    assign size        = lsu_size_e'(req_size_i);
    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign req_err     = is_misaligned(size, addr_i[1:0]);
    // Reset wins over a same-cycle store or load so no memory side effect escapes.
    assign do_write    = accept & req_write_i & ~req_err & ~rst_i;
    assign do_read     = accept & ~req_write_i & ~req_err & ~rst_i;
    assign wr_en       = do_write ? byte_en(size, addr_i[1:0]) : 4'b0000;
    assign unused_addr = ^addr_i[31:IDX_W+2];

    always_comb begin
        case (size)
            BYTE:    wr_data = {4{wdata_i[7:0]}};
            HALF:    wr_data = {2{wdata_i[15:0]}};
            default: wr_data = wdata_i;
        endcase
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk_i (clk_i),
        .rd_en (do_read),
        .wr_en (wr_en),
        .idx   (addr_i[IDX_W+1:2]),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    always_comb begin
        shifted  = rd_word >> {req_q.byte_off, 3'b000};
        load_fmt = rd_word;
        case (req_q.size)
            BYTE:    load_fmt = {{24{~req_q.is_unsigned & shifted[7]}},  shifted[7:0]};
            HALF:    load_fmt = {{16{~req_q.is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_fmt = rd_word;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_read) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rdata_o     <= '0;
            req_q       <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rdata_o     <= '0;
            // Stores and errors answer immediately; loads answer once the RAM word is back.
            if (accept && (req_write_i || req_err)) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= req_err;
            end else if (state_q == LOAD && !req_q.write) begin
                rsp_valid_o <= 1'b1;
                rdata_o     <= load_fmt;
            end
            if (accept)
                req_q <= '{write: req_write_i, size: size,
                           is_unsigned: req_unsigned_i, byte_off: addr_i[1:0]};
        end
    end

endmodule
